// File: rtl/ili9341_spi_rx_pkg.sv
// Shared constants and FSM encoding for the ILI9341 SPI receive path.
package ili9341_pkg;
  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  localparam int H_RES_DEF = 240;
  localparam int V_RES_DEF = 320;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET_ARG,
    ST_PASET_ARG,
    ST_RAMWR,
    ST_IGNORE
  } state_t;
endpackage

// File: rtl/ili9341_spi_rx_if.sv
// SPI link from the controller plus the decoded command/pixel stream.
interface ili9341_spi_rx_if;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_cs;
  logic        spi_dc;
  logic        cmd_valid;
  logic [7:0]  cmd_byte;
  logic        frame_start;
  logic        pix_valid;
  logic [8:0]  pix_x;
  logic [8:0]  pix_y;
  logic [15:0] pix_data;
  logic        err;

  modport master (
    output spi_sclk, spi_mosi, spi_cs, spi_dc,
    input  cmd_valid, cmd_byte, frame_start, pix_valid, pix_x, pix_y, pix_data, err
  );

  modport slave (
    input  spi_sclk, spi_mosi, spi_cs, spi_dc,
    output cmd_valid, cmd_byte, frame_start, pix_valid, pix_x, pix_y, pix_data, err
  );
endinterface

// File: rtl/spi_byte_rx.sv
// Oversampling SPI mode-0 byte deserialiser; emits a byte and its D/C flag.
module spi_byte_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       cs,
  input  logic       dc,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc
);
  logic [1:0] sclk_sync, mosi_sync, cs_sync, dc_sync;
  logic       sclk_d;
  logic [2:0] bit_cnt;
  logic [7:0] shift_p1;
  logic       vld_p1;
  logic       dc_p1;
  logic       sclk_rise;

  assign sclk_rise = sclk_sync[1] & ~sclk_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync  <= 2'b00;
      mosi_sync  <= 2'b00;
      cs_sync    <= 2'b11;
      dc_sync    <= 2'b00;
      sclk_d     <= 1'b0;
      bit_cnt    <= 3'd0;
      vld_p1     <= 1'b0;
      dc_p1      <= 1'b0;
      byte_valid <= 1'b0;
      byte_data  <= 8'h00;
      byte_dc    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      mosi_sync <= {mosi_sync[0], mosi};
      cs_sync   <= {cs_sync[0], cs};
      dc_sync   <= {dc_sync[0], dc};
      sclk_d    <= sclk_sync[1];
      // p1: bit capture on a synchronised rising edge
      vld_p1    <= 1'b0;
      if (cs_sync[1]) begin
        bit_cnt <= 3'd0;
      end else if (sclk_rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          vld_p1 <= 1'b1;
          dc_p1  <= dc_sync[1];
        end
      end
      // p2: completed byte handed to the decoder
      byte_valid <= vld_p1;
      if (vld_p1) begin
        byte_data <= shift_p1;
        byte_dc   <= dc_p1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!cs_sync[1] && sclk_rise)
      shift_p1 <= {shift_p1[6:0], mosi_sync[1]};
  end
endmodule

// File: rtl/ili9341_spi_rx.sv
// ILI9341 panel-side decoder: CASET/PASET window, RAMWR pixel stream with (x,y).
module ili9341_spi_rx
  import ili9341_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input logic              clk,
  input logic              rst,
  ili9341_spi_rx_if.slave  bus
);
  localparam logic [15:0] X_LIM = 16'(H_RES);
  localparam logic [15:0] Y_LIM = 16'(V_RES);

  logic       byte_valid, byte_dc;
  logic [7:0] byte_data;

  spi_byte_rx u_byte (
    .clk        (clk),
    .rst        (rst),
    .sclk       (bus.spi_sclk),
    .mosi       (bus.spi_mosi),
    .cs         (bus.spi_cs),
    .dc         (bus.spi_dc),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_dc    (byte_dc)
  );

  state_t      state, state_nx;
  logic [1:0]  arg_cnt, arg_cnt_nx;
  logic        have_hi, have_hi_nx;
  logic [8:0]  xs, xe, ys, ye, cx, cy;
  logic [8:0]  xs_nx, xe_nx, ys_nx, ye_nx, cx_nx, cy_nx;
  logic [7:0]  arg0, arg1, arg2, hi_byte;
  logic [7:0]  arg0_nx, arg1_nx, arg2_nx, hi_byte_nx;
  logic        cmd_valid, cmd_valid_nx, frame_start, frame_start_nx;
  logic        pix_valid, pix_valid_nx, err, err_nx;
  logic [7:0]  cmd_byte, cmd_byte_nx;
  logic [8:0]  pix_x, pix_x_nx, pix_y, pix_y_nx;
  logic [15:0] pix_data, pix_data_nx;
  logic [15:0] sc, ec, lim;

  always_comb begin
    state_nx = state;       arg_cnt_nx = arg_cnt;   have_hi_nx = have_hi;
    xs_nx = xs;  xe_nx = xe;  ys_nx = ys;  ye_nx = ye;  cx_nx = cx;  cy_nx = cy;
    arg0_nx = arg0;  arg1_nx = arg1;  arg2_nx = arg2;  hi_byte_nx = hi_byte;
    cmd_valid_nx = 1'b0;    frame_start_nx = 1'b0;  pix_valid_nx = 1'b0;  err_nx = 1'b0;
    cmd_byte_nx = cmd_byte; pix_x_nx = pix_x;  pix_y_nx = pix_y;  pix_data_nx = pix_data;
    sc  = {arg0, arg1};
    ec  = {arg2, byte_data};
    lim = (state == ST_CASET_ARG) ? X_LIM : Y_LIM;

    if (byte_valid && !byte_dc) begin
      // A command always restarts decoding, dropping partial arguments/pixels.
      cmd_valid_nx = 1'b1;
      cmd_byte_nx  = byte_data;
      arg_cnt_nx   = 2'd0;
      have_hi_nx   = 1'b0;
      case (byte_data)
        CMD_CASET: state_nx = ST_CASET_ARG;
        CMD_PASET: state_nx = ST_PASET_ARG;
        CMD_RAMWR: begin
          state_nx       = ST_RAMWR;
          frame_start_nx = 1'b1;
          cx_nx          = xs;
          cy_nx          = ys;
        end
        default:   state_nx = ST_IGNORE;
      endcase
    end else if (byte_valid) begin
      case (state)
        ST_CASET_ARG, ST_PASET_ARG: begin
          arg_cnt_nx = arg_cnt + 2'd1;
          case (arg_cnt)
            2'd0: arg0_nx = byte_data;
            2'd1: arg1_nx = byte_data;
            2'd2: arg2_nx = byte_data;
            default: begin
              state_nx = ST_IGNORE;
              if (sc > ec || ec >= lim) begin
                err_nx = 1'b1;
              end else if (state == ST_CASET_ARG) begin
                xs_nx = sc[8:0];
                xe_nx = ec[8:0];
              end else begin
                ys_nx = sc[8:0];
                ye_nx = ec[8:0];
              end
            end
          endcase
        end
        ST_RAMWR: begin
          have_hi_nx = ~have_hi;
          if (!have_hi) begin
            hi_byte_nx = byte_data;
          end else begin
            pix_valid_nx = 1'b1;
            pix_data_nx  = {hi_byte, byte_data};
            pix_x_nx     = cx;
            pix_y_nx     = cy;
            if (cx == xe) begin
              cx_nx = xs;
              cy_nx = (cy == ye) ? ys : cy + 9'd1;
            end else begin
              cx_nx = cx + 9'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      arg_cnt     <= 2'd0;
      have_hi     <= 1'b0;
      xs          <= 9'd0;
      xe          <= 9'(H_RES - 1);
      ys          <= 9'd0;
      ye          <= 9'(V_RES - 1);
      cx          <= 9'd0;
      cy          <= 9'd0;
      cmd_valid   <= 1'b0;
      cmd_byte    <= 8'h00;
      frame_start <= 1'b0;
      pix_valid   <= 1'b0;
      pix_x       <= 9'd0;
      pix_y       <= 9'd0;
      pix_data    <= 16'h0000;
      err         <= 1'b0;
    end else begin
      state       <= state_nx;
      arg_cnt     <= arg_cnt_nx;
      have_hi     <= have_hi_nx;
      xs          <= xs_nx;
      xe          <= xe_nx;
      ys          <= ys_nx;
      ye          <= ye_nx;
      cx          <= cx_nx;
      cy          <= cy_nx;
      cmd_valid   <= cmd_valid_nx;
      cmd_byte    <= cmd_byte_nx;
      frame_start <= frame_start_nx;
      pix_valid   <= pix_valid_nx;
      pix_x       <= pix_x_nx;
      pix_y       <= pix_y_nx;
      pix_data    <= pix_data_nx;
      err         <= err_nx;
    end
  end

  always_ff @(posedge clk) begin
    arg0    <= arg0_nx;
    arg1    <= arg1_nx;
    arg2    <= arg2_nx;
    hi_byte <= hi_byte_nx;
  end

  assign bus.cmd_valid   = cmd_valid;
  assign bus.cmd_byte    = cmd_byte;
  assign bus.frame_start = frame_start;
  assign bus.pix_valid   = pix_valid;
  assign bus.pix_x       = pix_x;
  assign bus.pix_y       = pix_y;
  assign bus.pix_data    = pix_data;
  assign bus.err         = err;
endmodule

// File: tb/tb_ili9341_spi_rx.sv
// Scoreboard bench for ili9341_spi_rx: SPI stimulus, queued expected commands/pixels.
module tb_ili9341_spi_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rise_cyc = 0;
  int   err_cnt = 0;
  int   fs_cnt = 0;

  logic [7:0]  cmd_q[$];
  logic [33:0] pix_q[$];

  ili9341_spi_rx_if bus ();

  ili9341_spi_rx #(.H_RES(240), .V_RES(320)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cmd_valid && bus.pix_valid) chk("cmd_pix_overlap", 1, 0);
      if (bus.err) err_cnt++;
      if (bus.frame_start) fs_cnt++;
      if (bus.cmd_valid) begin
        chk("cmd_latency", cyc - rise_cyc, 4);
        if (cmd_q.size() == 0) chk("cmd_unexpected", {24'd0, bus.cmd_byte}, 32'hFFFF_FFFF);
        else chk("cmd_byte", {24'd0, bus.cmd_byte}, {24'd0, cmd_q.pop_front()});
      end
      if (bus.pix_valid) begin
        chk("pix_latency", cyc - rise_cyc, 4);
        if (pix_q.size() == 0) begin
          chk("pix_unexpected", {16'd0, bus.pix_data}, 32'hFFFF_FFFF);
        end else begin
          logic [33:0] e;
          e = pix_q.pop_front();
          chk("pix_x", {23'd0, bus.pix_x}, {23'd0, e[33:25]});
          chk("pix_y", {23'd0, bus.pix_y}, {23'd0, e[24:16]});
          chk("pix_data", {16'd0, bus.pix_data}, {16'd0, e[15:0]});
        end
      end
    end
  end

  task automatic spi_bit(input logic b, input logic dc, input bit last);
    @(negedge clk);
    bus.spi_mosi = b;
    bus.spi_dc   = dc;
    repeat (3) @(negedge clk);
    bus.spi_sclk = 1'b1;
    if (last) rise_cyc = cyc + 1;
    repeat (4) @(negedge clk);
    bus.spi_sclk = 1'b0;
  endtask

  task automatic send_byte(input logic dc, input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i], dc, i == 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    cmd_q.push_back(c);
    send_byte(1'b0, c);
  endtask

  task automatic send_pix(input logic [8:0] x, input logic [8:0] y, input logic [15:0] d);
    pix_q.push_back({x, y, d});
    send_byte(1'b1, d[15:8]);
    send_byte(1'b1, d[7:0]);
  endtask

  task automatic send_win(input logic [7:0] c, input logic [15:0] s, input logic [15:0] e);
    send_cmd(c);
    send_byte(1'b1, s[15:8]);
    send_byte(1'b1, s[7:0]);
    send_byte(1'b1, e[15:8]);
    send_byte(1'b1, e[7:0]);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_cmd_valid"}, {31'd0, bus.cmd_valid}, 0);
    chk({tag, "_cmd_byte"}, {24'd0, bus.cmd_byte}, 0);
    chk({tag, "_frame_start"}, {31'd0, bus.frame_start}, 0);
    chk({tag, "_pix_valid"}, {31'd0, bus.pix_valid}, 0);
    chk({tag, "_pix_x"}, {23'd0, bus.pix_x}, 0);
    chk({tag, "_pix_y"}, {23'd0, bus.pix_y}, 0);
    chk({tag, "_pix_data"}, {16'd0, bus.pix_data}, 0);
    chk({tag, "_err"}, {31'd0, bus.err}, 0);
  endtask

  initial begin
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.spi_cs   = 1'b1;
    bus.spi_dc   = 1'b0;
    repeat (4) @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    bus.spi_cs = 1'b0;
    repeat (3) @(negedge clk);

    // Default window, first two pixels
    send_cmd(8'h2C);
    send_pix(9'd0, 9'd0, 16'hF800);
    send_pix(9'd1, 9'd0, 16'h07E0);
    chk("frame_start_count", fs_cnt, 1);

    // 2x2 window with wrap back to origin
    send_win(8'h2A, 16'd10, 16'd11);
    send_win(8'h2B, 16'd5, 16'd6);
    send_cmd(8'h2C);
    send_pix(9'd10, 9'd5, 16'h1001);
    send_pix(9'd11, 9'd5, 16'h1002);
    send_pix(9'd10, 9'd6, 16'h1003);
    send_pix(9'd11, 9'd6, 16'h1004);
    send_pix(9'd10, 9'd5, 16'h1005);
    chk("err_after_valid_windows", err_cnt, 0);
    chk("frame_start_count2", fs_cnt, 2);

    // SC > EC rejected; window kept
    send_win(8'h2A, 16'd20, 16'd10);
    chk("err_sc_gt_ec", err_cnt, 1);
    send_cmd(8'h2C);
    send_pix(9'd10, 9'd5, 16'hBEEF);

    // EC at H_RES and V_RES rejected
    send_win(8'h2A, 16'd0, 16'h00F0);
    chk("err_ec_hres", err_cnt, 2);
    send_win(8'h2B, 16'd0, 16'h0140);
    chk("err_ec_vres", err_cnt, 3);

    // Half pixel aborted by a command
    send_cmd(8'h2C);
    send_byte(1'b1, 8'hAB);
    send_cmd(8'h00);

    // Partial byte dropped by cs deassertion
    for (int i = 0; i < 5; i++) spi_bit(1'b1, 1'b1, 1'b0);
    bus.spi_cs = 1'b1;
    repeat (6) @(negedge clk);
    bus.spi_cs = 1'b0;
    repeat (3) @(negedge clk);
    send_cmd(8'h2C);
    send_pix(9'd10, 9'd5, 16'h1234);
    chk("pix_queue_drained", pix_q.size(), 0);

    // Reset in the middle of a pixel
    send_cmd(8'h2C);
    send_byte(1'b1, 8'h55);
    for (int i = 0; i < 3; i++) spi_bit(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    bus.spi_sclk = 1'b0;
    @(negedge clk);
    chk_outputs_zero("midrst");
    bus.spi_cs = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    bus.spi_cs = 1'b0;
    repeat (3) @(negedge clk);
    err_cnt = 0;
    send_cmd(8'h2C);
    send_pix(9'd0, 9'd0, 16'hCAFE);
    send_win(8'h2A, 16'd0, 16'h00EF);
    chk("err_ec_max_legal", err_cnt, 0);

    repeat (10) @(negedge clk);
    chk("cmd_queue_empty", cmd_q.size(), 0);
    chk("pix_queue_empty", pix_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
